// File: rtl/ycbcr_pkg.sv
// Shared constants, FSM state type and pixel rounding/clamping helpers for the 4:2:2 packer.
package ycbcr_pkg;

  localparam int Y0_MSB = 31;
  localparam int CB_MSB = 23;
  localparam int Y1_MSB = 15;
  localparam int CR_MSB = 7;

  localparam logic [15:0] ROUND_HALF  = 16'h0080;
  localparam logic [7:0]  BT601_Y_MIN = 8'd16;
  localparam logic [7:0]  BT601_Y_MAX = 8'd235;
  localparam logic [7:0]  BT601_C_MIN = 8'd16;
  localparam logic [7:0]  BT601_C_MAX = 8'd240;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  // Q8.8 to 8 bits, round half up; a carry into bit 16 means the result exceeds 255.
  function automatic logic [7:0] round_sat(input logic [15:0] v);
    logic [16:0] s;
    s = {1'b0, v} + {1'b0, ROUND_HALF};
    if (s[16]) begin
      return 8'hFF;
    end else begin
      return s[15:8];
    end
  endfunction

  function automatic logic [7:0] clamp_y(input logic [7:0] v);
    if (v < BT601_Y_MIN) begin
      return BT601_Y_MIN;
    end else if (v > BT601_Y_MAX) begin
      return BT601_Y_MAX;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [7:0] clamp_c(input logic [7:0] v);
    if (v < BT601_C_MIN) begin
      return BT601_C_MIN;
    end else if (v > BT601_C_MAX) begin
      return BT601_C_MAX;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is ignored unless a pop
// happens in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   din,
  input  logic               pop,
  output logic [WIDTH-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
  assign do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;

endmodule

// File: rtl/ycbcr422_packer.sv
// Rounds Q8.8 Y/Cb/Cr to 8 bits, averages chroma over pixel pairs and queues packed 4:2:2 words.
// Define YCC_BT601_CLAMP_EN to clamp to BT.601 studio range (Y 16..235, C 16..240).
module ycbcr422_packer
  import ycbcr_pkg::*;
#(
  parameter int LINE_W     = 640,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_y,
  input  logic [15:0] in_cb,
  input  logic [15:0] in_cr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_eol,
  output logic        overflow
);

  localparam int CW = $clog2(LINE_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_W - 1);

  state_t        state_r, state_s;
  logic [7:0]    y_s, cb_s, cr_s;
  logic [7:0]    y0_r, cb0_r, cr0_r;
  logic [8:0]    cb_sum_s, cr_sum_s;
  logic [31:0]   word_s;
  logic [CW-1:0] col_r;
  logic          eol_s, push_s, pop_s, overflow_r;
  logic [32:0]   fifo_dout_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [AW:0]   fifo_count_s;

`ifdef YCC_BT601_CLAMP_EN
  assign y_s  = clamp_y(round_sat(in_y));
  assign cb_s = clamp_c(round_sat(in_cb));
  assign cr_s = clamp_c(round_sat(in_cr));
`else
  assign y_s  = round_sat(in_y);
  assign cb_s = round_sat(in_cb);
  assign cr_s = round_sat(in_cr);
`endif

  assign eol_s = (col_r == LAST_COL);
  assign pop_s = out_ready && !fifo_empty_s;

  always_comb begin
    state_s  = state_r;
    push_s   = 1'b0;
    cb_sum_s = {1'b0, cb0_r} + {1'b0, cb_s} + 9'd1;
    cr_sum_s = {1'b0, cr0_r} + {1'b0, cr_s} + 9'd1;
    word_s   = 32'd0;
    word_s[Y0_MSB -: 8] = y0_r;
    word_s[CB_MSB -: 8] = cb_sum_s[8:1];
    word_s[Y1_MSB -: 8] = y_s;
    word_s[CR_MSB -: 8] = cr_sum_s[8:1];
    if (in_valid) begin
      case (state_r)
        EVEN: state_s = ODD;
        ODD: begin
          state_s = EVEN;
          push_s  = 1'b1;
        end
        default: state_s = EVEN;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // The FSM and column keep advancing on a drop so line alignment is never lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= EVEN;
      y0_r       <= 8'd0;
      cb0_r      <= 8'd0;
      cr0_r      <= 8'd0;
      col_r      <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (in_valid && (state_r == EVEN)) begin
        y0_r  <= y_s;
        cb0_r <= cb_s;
        cr0_r <= cr_s;
      end
      if (in_valid) begin
        col_r <= eol_s ? {CW{1'b0}} : col_r + CW'(1);
      end
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH(33),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   ({word_s, eol_s}),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign out_valid = (fifo_count_s != {(AW+1){1'b0}});
  assign out_data  = fifo_dout_s[32:1];
  assign out_eol   = fifo_dout_s[0];
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_ycbcr422_packer.sv
// Directed self-checking bench for ycbcr422_packer with LINE_W=4, FIFO_DEPTH=4.
module tb_ycbcr422_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_y = 16'h0000;
  logic [15:0] in_cb = 16'h0000;
  logic [15:0] in_cr = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_eol;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  ycbcr422_packer #(.LINE_W(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_eol(out_eol),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // One valid pixel for one cycle; starts and ends on a falling edge.
  task automatic send_pixel(input logic [15:0] y, input logic [15:0] cb, input logic [15:0] cr,
                            input logic rdy);
    in_valid = 1'b1; in_y = y; in_cb = cb; in_cr = cr; out_ready = rdy;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic pop_word();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", out_data); end
    checks++; if (out_eol !== 1'b0) begin failures++; $display("FAIL reset_eol got=%b exp=0", out_eol); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    reset = 1'b1;
  endtask

  task automatic test_round_pack();
    send_pixel(16'h4D80, 16'h8000, 16'h7F7F, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pack_half_valid got=%b exp=0", out_valid); end
    send_pixel(16'h1000, 16'h8100, 16'h7F7F, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pack_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h4E81107F) begin failures++; $display("FAIL pack_data got=%h exp=4e81107f", out_data); end
    checks++; if (out_eol !== 1'b0) begin failures++; $display("FAIL pack_eol got=%b exp=0", out_eol); end
    pop_word();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pack_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [31:0] exp_w;
`ifdef YCC_BT601_CLAMP_EN
    exp_w = 32'hEB80EB80;
`else
    exp_w = 32'hFF80FF80;
`endif
    send_pixel(16'hFFC0, 16'h8000, 16'h8000, 1'b0);
    send_pixel(16'hFFC0, 16'h8000, 16'h8000, 1'b0);
    checks++; if (out_data !== exp_w) begin failures++; $display("FAIL sat_data got=%h exp=%h", out_data, exp_w); end
    checks++; if (out_eol !== 1'b1) begin failures++; $display("FAIL sat_eol got=%b exp=1", out_eol); end
    pop_word();
  endtask

  task automatic test_eol_back_to_back();
    logic [3:0] exp_eol;
    exp_eol = 4'b1010;
    for (int i = 0; i < 8; i++) send_pixel(16'h2000, 16'h8000, 16'h8000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL eol_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_eol !== exp_eol[i]) begin failures++; $display("FAIL eol_flag[%0d] got=%b exp=%b", i, out_eol, exp_eol[i]); end
      pop_word();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL eol_drained got=%b exp=0", out_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL eol_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] y;
    logic [31:0] exp_w;
    for (int i = 0; i < 5; i++) begin
      y = 8'h40 + 8'(i);
      send_pixel({y, 8'h00}, 16'h8000, 16'h8000, 1'b0);
      send_pixel({y, 8'h00}, 16'h8000, 16'h8000, 1'b0);
      if (i == 3) begin
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before got=%b exp=0", overflow); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", out_valid); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    repeat (2) @(negedge clk);
    checks++; if (out_data !== 32'h40804080) begin failures++; $display("FAIL ovf_stable got=%h exp=40804080", out_data); end
    for (int i = 0; i < 4; i++) begin
      y = 8'h40 + 8'(i);
      exp_w = {y, 8'h80, y, 8'h80};
      checks++; if (out_data !== exp_w) begin failures++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, out_data, exp_w); end
      pop_word();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", out_valid); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] y;
    logic [31:0] exp_w;
    for (int i = 0; i < 4; i++) begin
      y = 8'h20 + 8'(i);
      send_pixel({y, 8'h00}, 16'h8000, 16'h8000, 1'b0);
      send_pixel({y, 8'h00}, 16'h8000, 16'h8000, 1'b0);
    end
    checks++; if (out_data !== 32'h20802080) begin failures++; $display("FAIL full_head got=%h exp=20802080", out_data); end
    send_pixel(16'h2400, 16'h8000, 16'h8000, 1'b0);
    send_pixel(16'h2400, 16'h8000, 16'h8000, 1'b1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_no_drop got=%b exp=0", overflow); end
    for (int i = 1; i < 5; i++) begin
      y = 8'h20 + 8'(i);
      exp_w = {y, 8'h80, y, 8'h80};
      checks++; if (out_data !== exp_w || out_valid !== 1'b1) begin
        failures++; $display("FAIL full_drain[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, exp_w);
      end
      pop_word();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_midpair_reset();
    do_reset();
    send_pixel(16'h3000, 16'h8000, 16'h8000, 1'b0);
    send_pixel(16'h3000, 16'h8000, 16'h8000, 1'b0);
    checks++; if (out_data !== 32'h30803080) begin failures++; $display("FAIL mid_pre got=%h exp=30803080", out_data); end
    pop_word();
    send_pixel(16'h5500, 16'h2000, 16'hE000, 1'b0);
    do_reset();
    repeat (3) @(negedge clk);
    send_pixel(16'h6000, 16'h9000, 16'h7000, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_half got=%b exp=0", out_valid); end
    send_pixel(16'h6200, 16'h9200, 16'h7200, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h60916271) begin failures++; $display("FAIL mid_data got=%h exp=60916271", out_data); end
    checks++; if (out_eol !== 1'b0) begin failures++; $display("FAIL mid_eol got=%b exp=0", out_eol); end
    pop_word();
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_single got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_round_pack();
    test_saturation();
    test_eol_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_midpair_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
